// File: rtl/rep_serial_encoder.sv
// Serial repetition-code transmitter: sends a parallel word MSB-first, each bit held for REP chips.
// Optional feature: define REP_PARITY_EN to append an even-parity bit after the LSB.
module rep_serial_encoder #(
  parameter int DATA_W = 8,
  parameter int REP    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_valid,
  output logic              frame_start,
  output logic              busy
);

`ifdef REP_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam int CHIP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(REP - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NBITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]        state;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  shifted;
  logic [NBITS-1:0]  load_word;
  logic [CHIP_W-1:0] chip_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              chip_wrap;
  logic              last_chip;
  logic              accept;

`ifdef REP_PARITY_EN
  assign load_word = {in_data, ^in_data};
`else
  assign load_word = in_data;
`endif

  assign shifted   = shreg << 1;
  assign chip_wrap = (state == SEND) && (chip_cnt == LAST_CHIP);
  assign last_chip = chip_wrap && (bit_cnt == LAST_BIT);
  assign in_ready  = (state == IDLE) || last_chip;
  assign accept    = in_valid && in_ready;
  assign busy      = tx_valid;

  // A word accepted on the last chip reloads directly, so back-to-back frames have no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      chip_cnt    <= '0;
      bit_cnt     <= '0;
      tx_out      <= 1'b0;
      tx_valid    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (accept) begin
        state       <= SEND;
        shreg       <= load_word;
        chip_cnt    <= '0;
        bit_cnt     <= '0;
        tx_out      <= load_word[NBITS-1];
        tx_valid    <= 1'b1;
        frame_start <= 1'b1;
      end else if (state == SEND) begin
        if (chip_wrap) begin
          chip_cnt <= '0;
          if (bit_cnt == LAST_BIT) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b0;
            tx_valid <= 1'b0;
          end else begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
            tx_out  <= shifted[NBITS-1];
          end
        end else begin
          chip_cnt <= chip_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rep_serial_encoder.sv
// Scoreboard bench for rep_serial_encoder: stimulus pushes expected chips, a monitor pops and compares.
module tb_rep_serial_encoder;

  localparam int DATA_W = 8;
  localparam int REP    = 7;
`ifdef REP_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int FRAME = NBITS * REP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              tx_out;
  logic              tx_valid;
  logic              frame_start;
  logic              busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [1:0] expQ[$];

  rep_serial_encoder #(.DATA_W(DATA_W), .REP(REP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_out(tx_out), .tx_valid(tx_valid), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected chip stream for one frame: {chip value, frame_start}.
  task automatic pushExpected(input logic [DATA_W-1:0] w);
    logic [NBITS-1:0] bits;
`ifdef REP_PARITY_EN
    bits = {w, ^w};
`else
    bits = w;
`endif
    for (int b = NBITS - 1; b >= 0; b--)
      for (int c = 0; c < REP; c++)
        expQ.push_back({bits[b], (b == NBITS - 1 && c == 0) ? 1'b1 : 1'b0});
  endtask

  always @(negedge clk) begin
    checkOutput("busy_eq_valid", {31'b0, busy}, {31'b0, tx_valid});
    if (tx_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_chip", 32'd1, 32'd0);
      end else begin
        logic [1:0] e;
        e = expQ.pop_front();
        checkOutput("chip", {30'b0, tx_out, frame_start}, {30'b0, e});
      end
    end else begin
      checkOutput("idle_tx_out", {31'b0, tx_out}, 32'd0);
      checkOutput("idle_frame_start", {31'b0, frame_start}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] w, input bit keep, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc = cyc;
      return;
    end
    pushExpected(w);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic waitNeg(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) checkOutput("wait_timeout", cyc, target);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((expQ.size() != 0 || tx_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drained", expQ.size(), 32'd0);
    checkOutput("idle_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int a, a2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_valid", {31'b0, tx_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("idle_tx_valid", {31'b0, tx_valid}, 32'd0);
    end

    // Single word 0x63 with timing of the final chip and return to IDLE.
    applyStimulus(8'h63, 1'b0, a);
    waitNeg(a + FRAME - 2);
    checkOutput("single_ready_before_last", {31'b0, in_ready}, 32'd0);
    waitNeg(a + FRAME - 1);
    checkOutput("single_ready_last", {31'b0, in_ready}, 32'd1);
    checkOutput("single_valid_last", {31'b0, tx_valid}, 32'd1);
    waitNeg(a + FRAME);
    checkOutput("single_valid_after", {31'b0, tx_valid}, 32'd0);
    waitIdle();

    // Back-to-back frames with in_valid held high.
    applyStimulus(8'h1C, 1'b1, a);
    applyStimulus(8'h77, 1'b0, a2);
    checkOutput("b2b_gap", a2 - a, FRAME);
    waitIdle();

    // Stall: in_valid pulsed mid-frame, in_data changed afterwards.
    applyStimulus(8'h20, 1'b0, a);
    waitNeg(a + 9);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 10; c <= 20; c++) begin
      waitNeg(a + c - 1);
      checkOutput("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    in_data  = 8'hAA;
    waitIdle();

    // Reset mid-frame abandons the frame.
    applyStimulus(8'h4B, 1'b0, a);
    waitNeg(a + 29);
    #2;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    checkOutput("midrst_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("midrst_tx_out", {31'b0, tx_out}, 32'd0);
    checkOutput("midrst_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(8'h65, 1'b0, a);
    waitNeg(a + FRAME - 1);
    checkOutput("post_rst_frame_len", {31'b0, tx_valid}, 32'd1);
    waitIdle();

    // Reset and accept in the same cycle: the word is dropped.
    @(negedge clk);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    checkOutput("rst_accept_valid", {31'b0, tx_valid}, 32'd0);
    @(negedge clk);
    checkOutput("rst_accept_valid2", {31'b0, tx_valid}, 32'd0);

`ifdef REP_PARITY_EN
    applyStimulus(8'h20, 1'b0, a);
    waitIdle();
    applyStimulus(8'h63, 1'b0, a);
    waitIdle();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
